// File: rtl/board_state_if.sv
// Board-state bus: move commands from the selector, board and game status back out.
interface board_state_if;
   logic       place;
   logic       newGame;
   logic [3:0] curBox;
   logic [1:0] out0, out1, out2, out3, out4, out5, out6, out7, out8;
   logic [1:0] player;
   logic [1:0] winner;
   logic       draw;
   logic       gameOver;
   logic [3:0] moveCount;

   modport master (
      output place, newGame, curBox,
      input  out0, out1, out2, out3, out4, out5, out6, out7, out8,
      input  player, winner, draw, gameOver, moveCount
   );

   modport slave (
      input  place, newGame, curBox,
      output out0, out1, out2, out3, out4, out5, out6, out7, out8,
      output player, winner, draw, gameOver, moveCount
   );
endinterface

// File: rtl/board_state.sv
// 3x3 tic-tac-toe board: commits moves, alternates turns, detects win/draw.
module board_state #(
   parameter logic [1:0] FIRST_PLAYER = 2'b01
) (
   input  logic         clk,
   input  logic         reset,
   board_state_if.slave bus
);

   typedef enum logic [2:0] {
      StXTurn = 3'd0,
      StOTurn = 3'd1,
      StCheck = 3'd2,
      StXWin  = 3'd3,
      StOWin  = 3'd4,
      StDraw  = 3'd5
   } state_e;

   localparam state_e FirstTurn = (FIRST_PLAYER == 2'b10) ? StOTurn : StXTurn;

   state_e     state_q, state_d;
   logic [1:0] cell_q [9];
   logic [1:0] cell_d [9];
   logic [3:0] move_count_q, move_count_d;
   logic [1:0] last_mark_q, last_mark_d;

   logic [1:0] turn_mark;
   logic       in_turn;
   logic       sel_empty;
   logic       valid_move;
   logic       line_done;

   assign in_turn   = (state_q == StXTurn) || (state_q == StOTurn);
   assign turn_mark = (state_q == StOTurn) ? 2'b10 : 2'b01;

   always_comb begin
      sel_empty = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (bus.curBox == 4'(i) && cell_q[i] == 2'b00) sel_empty = 1'b1;
      end
   end

   assign valid_move = bus.place && !bus.newGame && in_turn && sel_empty;

   // Only the mark that just moved can have completed a line.
   always_comb begin
      line_done = 1'b0;
      if ((cell_q[0] == last_mark_q && cell_q[1] == last_mark_q && cell_q[2] == last_mark_q) ||
          (cell_q[3] == last_mark_q && cell_q[4] == last_mark_q && cell_q[5] == last_mark_q) ||
          (cell_q[6] == last_mark_q && cell_q[7] == last_mark_q && cell_q[8] == last_mark_q) ||
          (cell_q[0] == last_mark_q && cell_q[3] == last_mark_q && cell_q[6] == last_mark_q) ||
          (cell_q[1] == last_mark_q && cell_q[4] == last_mark_q && cell_q[7] == last_mark_q) ||
          (cell_q[2] == last_mark_q && cell_q[5] == last_mark_q && cell_q[8] == last_mark_q) ||
          (cell_q[0] == last_mark_q && cell_q[4] == last_mark_q && cell_q[8] == last_mark_q) ||
          (cell_q[2] == last_mark_q && cell_q[4] == last_mark_q && cell_q[6] == last_mark_q)) begin
         line_done = (last_mark_q != 2'b00);
      end
   end

   always_comb begin
      state_d = state_q;
      if (bus.newGame) begin
         state_d = FirstTurn;
      end else begin
         case (state_q)
            StXTurn, StOTurn: if (valid_move) state_d = StCheck;
            StCheck: begin
               if (line_done)                   state_d = (last_mark_q == 2'b10) ? StOWin : StXWin;
               else if (move_count_q == 4'd9)   state_d = StDraw;
               else if (last_mark_q == 2'b10)   state_d = StXTurn;
               else                             state_d = StOTurn;
            end
            StXWin, StOWin, StDraw: state_d = state_q;
            default: state_d = FirstTurn;
         endcase
      end
   end

   always_comb begin
      cell_d       = cell_q;
      move_count_d = move_count_q;
      last_mark_d  = last_mark_q;
      if (bus.newGame) begin
         for (int i = 0; i < 9; i++) cell_d[i] = 2'b00;
         move_count_d = 4'd0;
         last_mark_d  = 2'b00;
      end else if (valid_move) begin
         for (int i = 0; i < 9; i++) begin
            if (bus.curBox == 4'(i)) cell_d[i] = turn_mark;
         end
         move_count_d = move_count_q + 4'd1;
         last_mark_d  = turn_mark;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= FirstTurn;
         move_count_q <= 4'd0;
         last_mark_q  <= 2'b00;
         for (int i = 0; i < 9; i++) cell_q[i] <= 2'b00;
      end else begin
         state_q      <= state_d;
         move_count_q <= move_count_d;
         last_mark_q  <= last_mark_d;
         for (int i = 0; i < 9; i++) cell_q[i] <= cell_d[i];
      end
   end

   assign bus.out0 = cell_q[0];
   assign bus.out1 = cell_q[1];
   assign bus.out2 = cell_q[2];
   assign bus.out3 = cell_q[3];
   assign bus.out4 = cell_q[4];
   assign bus.out5 = cell_q[5];
   assign bus.out6 = cell_q[6];
   assign bus.out7 = cell_q[7];
   assign bus.out8 = cell_q[8];

   assign bus.player    = (state_q == StXTurn) ? 2'b01 :
                          (state_q == StOTurn) ? 2'b10 : 2'b00;
   assign bus.winner    = (state_q == StXWin)  ? 2'b01 :
                          (state_q == StOWin)  ? 2'b10 : 2'b00;
   assign bus.draw      = (state_q == StDraw);
   assign bus.gameOver  = (state_q == StXWin) || (state_q == StOWin) || (state_q == StDraw);
   assign bus.moveCount = move_count_q;

endmodule
